// File: rtl/jackson_pkg.sv
// ---------------------------------------------------------------------------
// jackson_pkg
//   Shared definitions for the Jackson (factorized group-generate) adder.
//
//   Contents
//     GROUP            : leaf group size of the carry tree (4 bits)
//     W_NARROW/W_WIDE  : the two supported operand widths
//     TREE_*           : the supported carry-tree shape names
//     jterm_t          : Jackson term triple {d, b, q} of a bit/group span
//     bit_term()       : term of a single bit position
//     jackson_group()  : 4-bit group terms built straight from g/t vectors
//     combine2/4()     : merge 2 or 4 adjacent spans into one span term
//     child_carries2/4 : carry into each child span given the parent carry-in
//
//   Term meaning for a span (any size):
//     G = d & b         span generate
//     P = d & q         span propagate (transmit)
//     carry out = d & (b | q & carry in)
//   "d" is the enabling part shared by G and P (the top position's transmit),
//   which is factored out because a generate always implies a transmit.
// ---------------------------------------------------------------------------
package jackson_pkg;

  localparam int GROUP    = 4;

  localparam int W_NARROW = 16;
  localparam int W_WIDE   = 32;

  localparam string TREE_4X4   = "4x4";
  localparam string TREE_2X4X2 = "2x4x2";
  localparam string TREE_2X4X4 = "2x4x4";

  typedef struct packed {
    logic d;  // enabling part (transmit of the top position)
    logic b;  // generate part with d factored out
    logic q;  // transmit of the span below the top position
  } jterm_t;

  // A single bit: G = g = t & g, P = t, so d = t, b = g, q = 1.
  function automatic jterm_t bit_term(input logic g, input logic t);
    jterm_t r;
    r.d = t;
    r.b = g;
    r.q = 1'b1;
    return r;
  endfunction

  // 4-bit group. The classic group generate
  //   G = g3 | t3 g2 | t3 t2 g1 | t3 t2 t1 g0
  // factorizes (since g3 = t3 g3) as G = t3 & (g3 | g2 | t2 g1 | t2 t1 g0).
  function automatic jterm_t jackson_group(input logic [GROUP-1:0] g,
                                           input logic [GROUP-1:0] t);
    jterm_t r;
    r.d = t[3];
    r.b = g[3] | g[2] | (t[2] & g[1]) | (t[2] & t[1] & g[0]);
    r.q = t[2] & t[1] & t[0];
    return r;
  endfunction

  // Radix-4 merge of spans v[3] (most significant) .. v[0].
  // The top span's d is kept factored out of the merged generate.
  function automatic jterm_t combine4(input jterm_t [3:0] v);
    jterm_t     r;
    logic [3:0] gg;
    logic [3:0] pp;
    for (int i = 0; i < 4; i++) begin
      gg[i] = v[i].d & v[i].b;
      pp[i] = v[i].d & v[i].q;
    end
    r.d = v[3].d;
    r.b = v[3].b
        | (v[3].q & gg[2])
        | (v[3].q & pp[2] & gg[1])
        | (v[3].q & pp[2] & pp[1] & gg[0]);
    r.q = v[3].q & pp[2] & pp[1] & pp[0];
    return r;
  endfunction

  // Radix-2 merge of spans v[1] (upper) and v[0] (lower).
  function automatic jterm_t combine2(input jterm_t [1:0] v);
    jterm_t r;
    r.d = v[1].d;
    r.b = v[1].b | (v[1].q & v[0].d & v[0].b);
    r.q = v[1].q & v[0].d & v[0].q;
    return r;
  endfunction

  // Carry into each of four child spans, given the carry into the lowest.
  function automatic logic [3:0] child_carries4(input jterm_t [3:0] v,
                                                input logic cin);
    logic [3:0] c;
    c[0] = cin;
    for (int j = 1; j < 4; j++) begin
      c[j] = v[j-1].d & (v[j-1].b | (v[j-1].q & c[j-1]));
    end
    return c;
  endfunction

  // Carry into each of two child spans, given the carry into the lower one.
  function automatic logic [1:0] child_carries2(input jterm_t [1:0] v,
                                                input logic cin);
    logic [1:0] c;
    c[0] = cin;
    c[1] = v[0].d & (v[0].b | (v[0].q & cin));
    return c;
  endfunction

endpackage : jackson_pkg

// File: rtl/jackson_core.sv
// ---------------------------------------------------------------------------
// jackson_core
//   Purely combinational modulo-2^WIDTH adder with a recursive Jackson
//   carry tree. No carry-in, no carry-out.
//
//   Parameters
//     WIDTH : 16 or 32
//     TREE  : "4x4" or "2x4x2" when WIDTH=16, "2x4x4" when WIDTH=32
//             (shape read root-first: root radix x middle radix x leaf size)
//
//   Ports
//     a_i   [WIDTH-1:0]  operand A
//     b_i   [WIDTH-1:0]  operand B
//     sum_o [WIDTH-1:0]  (a_i + b_i) mod 2^WIDTH
//
//   Tree levels (bottom-up):
//     leaf   : 4-bit Jackson groups, or 2-bit spans for "2x4x2"
//     middle : radix-4 merge of leaves
//     root   : radix-2 merge of middles ("2x4x2", "2x4x4"); absent for "4x4"
//   Carries are then distributed top-down: each node hands its carry-in to
//   its children through their (d, b, q) terms. The whole-word term is never
//   formed because the carry out of the MSB is discarded.
// ---------------------------------------------------------------------------
module jackson_core
  import jackson_pkg::*;
#(
  parameter int    WIDTH = 16,
  parameter string TREE  = "4x4"
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  localparam bit LEGAL =
      ((WIDTH == W_NARROW) && ((TREE == TREE_4X4) || (TREE == TREE_2X4X2)))
   || ((WIDTH == W_WIDE)   &&  (TREE == TREE_2X4X4));

  localparam int LEAF_R = (TREE == TREE_2X4X2) ? 2 : GROUP;
  localparam int MID_R  = 4;
  localparam int N_LEAF = WIDTH / LEAF_R;
  localparam int N_MID  = N_LEAF / MID_R;  // 1 for "4x4", 2 otherwise

  if (!LEGAL) begin : g_illegal
    $error("jackson_core: unsupported WIDTH/TREE combination");
  end

  // Bit-level terms
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] c;

  assign g = a_i & b_i;
  assign t = a_i | b_i;
  assign x = a_i ^ b_i;

  // Leaf terms and the carry entering each leaf
  jterm_t [N_LEAF-1:0] leaf_t;
  logic   [N_LEAF-1:0] leaf_c;

  // Carry entering each middle node
  logic   [N_MID-1:0]  mid_c;

  // ---------------- leaf level ----------------
  for (genvar k = 0; k < N_LEAF; k++) begin : g_leaf
    jterm_t [LEAF_R-1:0] bits;

    for (genvar j = 0; j < LEAF_R; j++) begin : g_bit
      assign bits[j] = bit_term(g[LEAF_R*k+j], t[LEAF_R*k+j]);
    end

    if (LEAF_R == GROUP) begin : g_r4
      assign leaf_t[k]              = jackson_group(g[GROUP*k +: GROUP],
                                                    t[GROUP*k +: GROUP]);
      assign c[GROUP*k +: GROUP]    = child_carries4(bits, leaf_c[k]);
    end else begin : g_r2
      assign leaf_t[k]              = combine2(bits);
      assign c[2*k +: 2]            = child_carries2(bits, leaf_c[k]);
    end
  end

  // ---------------- middle level (radix 4) ----------------
  for (genvar m = 0; m < N_MID; m++) begin : g_mid
    assign leaf_c[MID_R*m +: MID_R] =
        child_carries4(leaf_t[MID_R*m +: MID_R], mid_c[m]);
  end

  // ---------------- root level ----------------
  if (N_MID == 1) begin : g_root1
    // Single middle node spans the whole word: its carry-in is c_0 = 0.
    assign mid_c = 1'b0;
  end else begin : g_root2
    // Radix-2 root: only the lower middle's term is needed to feed the
    // upper one; the upper middle's term would only produce carry-out.
    jterm_t [1:0] mid_t;
    for (genvar m = 0; m < 2; m++) begin : g_mt
      assign mid_t[m] = combine4(leaf_t[MID_R*m +: MID_R]);
    end
    assign mid_c = child_carries2(mid_t, 1'b0);
  end

  assign sum_o = x ^ c;

endmodule : jackson_core

// File: rtl/jackson_adder_reg.sv
// ---------------------------------------------------------------------------
// jackson_adder_reg
//   Registered modulo-2^WIDTH adder: jackson_core followed by one register
//   stage for the sum and its valid flag. Overflow wraps silently.
//
//   Parameters
//     WIDTH : 16 or 32
//     TREE  : carry-tree shape, see jackson_core
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset (clears sum and out_valid)
//     in_valid   operands a/b are valid this cycle
//     a, b       unsigned operands
//     out_valid  sum holds a result loaded on the previous edge
//     sum        registered (a + b) mod 2^WIDTH
//
//   Handshake: valid-only, no ready. A beat is accepted on every rising edge
//   where in_valid=1 and appears on sum with out_valid=1 exactly one cycle
//   later. There is no back-pressure; with in_valid=0 sum keeps its value and
//   out_valid is 0 for the following cycle.
// ---------------------------------------------------------------------------
module jackson_adder_reg
  import jackson_pkg::*;
#(
  parameter int    WIDTH = 16,
  parameter string TREE  = "4x4"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] a_gated;
  logic [WIDTH-1:0] b_gated;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             valid_d;
  logic             valid_q;

  // Operands are forced to zero when not valid so unknown or toggling
  // operand buses neither reach the adder nor the sum register.
  assign a_gated = in_valid ? a : '0;
  assign b_gated = in_valid ? b : '0;

  jackson_core #(
    .WIDTH (WIDTH),
    .TREE  (TREE)
  ) u_core (
    .a_i   (a_gated),
    .b_i   (b_gated),
    .sum_o (sum_d)
  );

  assign valid_d = in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (in_valid) begin
        sum_q <= sum_d;
      end
    end
  end

  assign sum       = sum_q;
  assign out_valid = valid_q;

endmodule : jackson_adder_reg

// File: tb/tb_jackson_adder_reg.sv
// ---------------------------------------------------------------------------
// tb_jackson_adder_reg
//   Drives three instances (16-bit "4x4", 16-bit "2x4x2", 32-bit "2x4x4")
//   with shared valid/reset and checks each against plain-arithmetic
//   expectations held in per-width expected queues.
// ---------------------------------------------------------------------------
module tb_jackson_adder_reg;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        in_valid;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [31:0] a32;
  logic [31:0] b32;

  logic [15:0] s16a;
  logic [15:0] s16b;
  logic [31:0] s32;
  logic        v16a;
  logic        v16b;
  logic        v32;

  jackson_adder_reg #(.WIDTH(16), .TREE("4x4")) u_dut16_4x4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a16),
    .b         (b16),
    .out_valid (v16a),
    .sum       (s16a)
  );

  jackson_adder_reg #(.WIDTH(16), .TREE("2x4x2")) u_dut16_2x4x2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a16),
    .b         (b16),
    .out_valid (v16b),
    .sum       (s16b)
  );

  jackson_adder_reg #(.WIDTH(32), .TREE("2x4x4")) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a32),
    .b         (b32),
    .out_valid (v32),
    .sum       (s32)
  );

  // ---------------- scoreboard ----------------
  int total;
  int bad;

  logic [15:0] exp16_q[$];
  logic [31:0] exp32_q[$];
  logic        expv_q[$];

  // Last loaded sums: what the registers must hold while in_valid=0.
  logic [15:0] last16;
  logic [31:0] last32;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Applies one beat and records what the next edge must produce.
  task automatic drive(input logic v,
                       input logic [15:0] x16, input logic [15:0] y16,
                       input logic [31:0] x32, input logic [31:0] y32);
    longint unsigned full;
    in_valid = v;
    a16 = x16;
    b16 = y16;
    a32 = x32;
    b32 = y32;
    if (v) begin
      full   = longint'(x16) + longint'(y16);
      last16 = 16'(full % 64'd65536);
      full   = longint'(x32) + longint'(y32);
      last32 = 32'(full % 64'h1_0000_0000);
    end
    exp16_q.push_back(last16);
    exp32_q.push_back(last32);
    expv_q.push_back(v);
  endtask

  // Advances one edge and compares all outputs against the oldest entry.
  task automatic step_check(input string tag);
    logic [15:0] e16;
    logic [31:0] e32;
    logic        ev;
    @(posedge clk);
    #1;
    if (exp16_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e16 = exp16_q.pop_front();
      e32 = exp32_q.pop_front();
      ev  = expv_q.pop_front();
      check({tag, "_sum16_4x4"},   32'(s16a), 32'(e16));
      check({tag, "_sum16_2x4x2"}, 32'(s16b), 32'(e16));
      check({tag, "_sum32"},       s32,       e32);
      check({tag, "_valid16_4x4"},   32'(v16a), 32'(ev));
      check({tag, "_valid16_2x4x2"}, 32'(v16b), 32'(ev));
      check({tag, "_valid32"},       32'(v32),  32'(ev));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sum16_4x4"},   32'(s16a), 32'd0);
    check({tag, "_sum16_2x4x2"}, 32'(s16b), 32'd0);
    check({tag, "_sum32"},       s32,       32'd0);
    check({tag, "_valid16_4x4"},   32'(v16a), 32'd0);
    check({tag, "_valid16_2x4x2"}, 32'(v16b), 32'd0);
    check({tag, "_valid32"},       32'(v32),  32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int unsigned seed_dummy;
  int          rand_bad_before;

  initial begin
    total    = 0;
    bad      = 0;
    last16   = '0;
    last32   = '0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a16 = '0; b16 = '0; a32 = '0; b32 = '0;
    seed_dummy = $urandom(32'h00C0_FFEE);

    // Reset asserted between edges takes effect immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");

    // Valid beats during reset must not load.
    in_valid = 1'b1;
    a16 = 16'hAAAA; b16 = 16'h1111;
    a32 = 32'h1234_5678; b32 = 32'h1111_1111;
    @(posedge clk);
    #1;
    check_zero("reset_held");
    rst_n = 1'b1;

    // Directed cases; first load on the first edge after release.
    drive(1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step_check("wrap");
    drive(1'b1, 16'h7FFF, 16'h0001, 32'h0000_FFFF, 32'h0000_0001);
    step_check("ripple");
    drive(1'b1, 16'h1234, 16'h4321, 32'h8000_0000, 32'h8000_0000);
    step_check("pattern");
    drive(1'b1, 16'h0000, 16'h0000, 32'h7FFF_FFFF, 32'h0000_0001);
    step_check("zero");

    // Hold: new (even unknown) operands with in_valid=0 leave sum alone.
    drive(1'b0, 16'h5A5A, 16'hA5A5, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    step_check("hold");
    drive(1'b0, 16'hxxxx, 16'hxxxx, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
    step_check("hold_x");
    drive(1'b1, 16'h8000, 16'h8000, 32'hFFFF_0000, 32'h0001_0000);
    step_check("after_hold");

    // Reset mid-stream: the beat in flight is lost, outputs clear at once.
    drive(1'b1, 16'h0F0F, 16'h0101, 32'h0F0F_0F0F, 32'h0101_0101);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    exp16_q.delete();
    exp32_q.delete();
    expv_q.delete();
    last16 = '0;
    last32 = '0;
    @(posedge clk);
    #1;
    check_zero("reset_mid_held");
    rst_n = 1'b1;

    // Random back-to-back beats for every shape.
    rand_bad_before = bad;
    for (int i = 0; i < 10000; i++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), $urandom, $urandom);
      step_check("rand");
    end
    $display("random back-to-back beats: %0d, mismatching checks: %0d",
             10000, bad - rand_bad_before);

    // Random mix of valid and idle beats, including edge operands.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] x16;
      logic [31:0] x32;
      x16 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      x32 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      drive(1'($urandom_range(0, 1)), x16, 16'($urandom), x32, $urandom);
      step_check("rand_mix");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_jackson_adder_reg
